dmem_sized: RTL
===============

Name: dmem_sized

Overview:
- Parametrised data memory for the pipelined CPU MEM stage. Successor to the single-cycle word-only data RAM.
- Adds configurable depth and address width, and byte/half/word accesses with load sign/zero extension.
- Adds a req/ready/valid handshake with programmable access latency, so the pipeline can stall on slow memory.
- Flags misaligned and out-of-range accesses instead of silently aliasing them.

Parameters:
- DEPTH, 32, number of 32-bit words; power of two, 2..4096; IDX_W = clog2(DEPTH).
- ADDR_W, 32, byte-address width; must satisfy ADDR_W >= IDX_W+2.
- LATENCY, 1, cycles from request acceptance to valid response; legal range 1..15.
- MEM_INIT, "dmem_init.txt", hex file loaded when DMEM_INIT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- req  in  1  request valid.
- ready  out  1  block can accept a request this cycle.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- unsigned_ld  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  ADDR_W  byte address.
- datain  in  32  store data; byte and half stores use the low bits.
- valid  out  1  one-cycle response pulse.
- dataout  out  32  load result, qualified by valid.
- err_misalign  out  1  response carries a misalignment or reserved-size error; qualified by valid.
- err_range  out  1  response carries an out-of-range error; qualified by valid.

Behaviour:
- States: IDLE, WAIT, RESP. ready = 1 in IDLE and RESP, 0 in WAIT.
- Acceptance: at an edge where req & ready, latch we, size, unsigned_ld, addr and datain.
  - LATENCY = 1: go directly to RESP.
  - LATENCY > 1: go to WAIT with cnt = LATENCY-2; WAIT decrements cnt each edge and goes to RESP at the edge where cnt = 0.
- The edge entering RESP is the commit edge:
  - a store writes the array;
  - a load registers dataout from the array contents before that edge's write (no same-edge forwarding is needed, since a single request is outstanding).
- valid = 1 only during RESP, for exactly one cycle. There is no response backpressure.
- In RESP, a new req is accepted (giving back-to-back throughput of 1 per cycle at LATENCY = 1). Otherwise RESP returns to IDLE.
- Address mapping: little-endian.
  - Word index = addr[IDX_W+1:2]; lane = addr[1:0].
  - Byte access uses lane bits 8*lane+7:8*lane.
  - Half access uses bits 16*addr[1]+15:16*addr[1].
- Stores update only the addressed bytes; other bytes of the word are preserved.
- Loads: a byte or half is extended to 32 bits per unsigned_ld; a word load ignores unsigned_ld.
- err_misalign is set when:
  - size = 01 and addr[0] = 1; or
  - size = 10 and addr[1:0] != 0; or
  - size = 11.
- err_range is set when addr[ADDR_W-1:2] >= DEPTH; it is never set when ADDR_W = IDX_W+2.
- Any error: no array write, dataout = 0, the relevant error flag(s) = 1 with valid. Both flags may be set together.
- Store response: dataout = 0.
- Reset (synchronous): state IDLE, cnt = 0, valid = 0, dataout = 0, both error flags 0.
  - Array contents are not cleared.
  - Reset during WAIT discards the pending access: a store is never written.
  - Reset coinciding with req: the request is not accepted.
- Input changes while in WAIT are ignored, because inputs are latched at acceptance.
- LATENCY outside 1..15 is a configuration error: stop simulation with $error at elaboration.

Optional Feature:
- Macro DMEM_INIT_EN.
- Defined: the array is initialised from MEM_INIT with $readmemh at time 0.
- Undefined: no file access, and array contents are X until written; the bench must write before it reads.

Test Plan:
- LATENCY=1: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> valid on the cycle after each accept; load dataout = 0xDEADBEEF; ready is never low.
- sb 0x80 to addr 0x11 over word 0x00000000, then lb 0x11 -> 0xFFFFFF80; lbu 0x11 -> 0x00000080; lw 0x10 -> 0x00008000.
- sh 0xBEEF to addr 0x22, then lh 0x22 -> 0xFFFFBEEF; lhu -> 0x0000BEEF; lw 0x20 -> 0xBEEF0000 (prior word zero).
- lw 0x13; sh 0x21; size=11 -> each gives err_misalign = 1 and dataout = 0; memory is unchanged when read back.
- DEPTH=32, ADDR_W=32: sw to addr 0x80 -> err_range = 1; lw 0x00 is unaffected (no aliasing).
- LATENCY=4: req held continuously -> ready low for 3 cycles, valid 4 cycles after accept, next accept in the RESP cycle. Assert rst during WAIT of a sw -> valid is never raised and the word keeps its old value.

Source files
------------

// File: rtl/dmem_sized.sv
// dmem_sized: parametrised data memory for the MEM stage.
// Byte/half/word accesses with sign/zero-extended loads, a req/ready/valid
// handshake with LATENCY cycles from acceptance to response, and error
// flags for misaligned or out-of-range accesses (no aliasing).
//
// state  | meaning
// IDLE   | no access outstanding, ready for a request
// WAIT   | access accepted, counting down the remaining latency
// RESP   | response cycle (valid=1), may accept the next request
module dmem_sized #(
  parameter int    DEPTH    = 32,
  parameter int    ADDR_W   = 32,
  parameter int    LATENCY  = 1,
  parameter string MEM_INIT = "dmem_init.txt"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ready,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       datain,
  output logic              valid,
  output logic [31:0]       dataout,
  output logic              err_misalign,
  output logic              err_range
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_sized: LATENCY %0d outside 1..15", LATENCY);
  end
  if (DEPTH < 2 || DEPTH > 4096 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
    $error("dmem_sized: DEPTH %0d must be a power of two in 2..4096", DEPTH);
  end
  if (ADDR_W < IDX_W + 2) begin : g_bad_addr_w
    $error("dmem_sized: ADDR_W %0d too small for DEPTH %0d", ADDR_W, DEPTH);
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_n;
  logic [3:0]        cnt;
  logic              accept, commit;

  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  logic              c_we, c_uns;
  logic [1:0]        c_size;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_data;
  logic [IDX_W-1:0]  c_idx;
  logic [1:0]        c_lane;
  logic              c_mis, c_rng, c_err;
  logic [31:0]       rd_word, ld_val, wdata;
  logic [3:0]        be;

  logic [31:0]       mem [DEPTH];

  // With single-cycle latency the accept edge is the commit edge, so the
  // live inputs are used; otherwise the operands latched at acceptance.
  always_comb begin
    if (LATENCY == 1) begin
      c_we   = we;
      c_size = size;
      c_uns  = unsigned_ld;
      c_addr = addr;
      c_data = datain;
    end else begin
      c_we   = we_q;
      c_size = size_q;
      c_uns  = uns_q;
      c_addr = addr_q;
      c_data = data_q;
    end
  end

  assign c_idx  = c_addr[IDX_W+1:2];
  assign c_lane = c_addr[1:0];
  assign c_mis  = (c_size == 2'b11) ||
                  (c_size == 2'b01 && c_addr[0]) ||
                  (c_size == 2'b10 && c_lane != 2'b00);

  if (ADDR_W > IDX_W + 2) begin : g_range
    assign c_rng = |c_addr[ADDR_W-1:IDX_W+2];
  end else begin : g_no_range
    assign c_rng = 1'b0;
  end

  assign c_err   = c_mis | c_rng;
  assign rd_word = mem[c_idx];

  // Load extraction/extension and store lane placement for the commit access.
  always_comb begin
    ld_val = rd_word;
    wdata  = c_data;
    be     = 4'b0000;
    case (c_size)
      2'b00: begin
        ld_val = {24'd0, rd_word[{c_lane, 3'b000} +: 8]};
        if (!c_uns && ld_val[7]) ld_val[31:8] = 24'hFF_FFFF;
        wdata  = {4{c_data[7:0]}};
        be     = 4'b0001 << c_lane;
      end
      2'b01: begin
        ld_val = {16'd0, rd_word[{c_addr[1], 4'b0000} +: 16]};
        if (!c_uns && ld_val[15]) ld_val[31:16] = 16'hFFFF;
        wdata  = {2{c_data[15:0]}};
        be     = c_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Next-state, handshake and commit decisions.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    commit  = 1'b0;
    ready   = (state != S_WAIT);
    valid   = (state == S_RESP);
    case (state)
      S_IDLE, S_RESP: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_n = S_RESP;
            commit  = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_n = S_RESP;
          commit  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, latency counter, request latch and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      dataout      <= 32'd0;
      err_misalign <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q   <= we;
        size_q <= size;
        uns_q  <= unsigned_ld;
        addr_q <= addr;
        data_q <= datain;
        cnt    <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_misalign <= c_mis;
        err_range    <= c_rng;
        dataout      <= (c_err || c_we) ? 32'd0 : ld_val;
      end
    end
  end

  // Array write on the commit edge; only the addressed bytes change.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[c_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule
